// File: rtl/debounce_pkg.sv
// debounce_pkg: tick conversion helpers and the per-channel event bundle shared by the debouncer.
package debounce_pkg;

  function automatic int ms_to_ticks(input int khz, input int ms);
    return khz * ms;
  endfunction

  function automatic int cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

  typedef struct packed {
    logic state;
    logic press;
    logic rls;
    logic lng;
  } btn_evt_t;

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one button channel: 2-FF synchroniser, stability filter, press/release strobes and,
// when LONG_PRESS_EN is defined, a hold counter producing long-press / auto-repeat strobes.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int TICKS      = 8,
  parameter int ACTIVE_LOW = 1
`ifdef LONG_PRESS_EN
  ,
  parameter int LONG_TICKS = 40,
  parameter int REP_TICKS  = 16
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     pad,
  output btn_evt_t evt
);

  localparam int   CW = cnt_width(TICKS);
  localparam logic AL = (ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          state, press, rls, lng, p, diff, fire;

  assign p    = sync[1] ^ AL;
  assign diff = p != state;
  assign fire = diff && (cnt == CW'(TICKS - 1));

  // Synchroniser resets to the released pad level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= {2{AL}};
    else        sync <= {sync[0], pad};

  // Filter: count consecutive disagreeing cycles; any agreement discards the count.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      state <= 1'b0;
      press <= 1'b0;
      rls   <= 1'b0;
    end else begin
      cnt   <= (diff && !fire) ? cnt + 1'b1 : '0;
      state <= fire ? p : state;
      press <= fire && p;
      rls   <= fire && !p;
    end

`ifdef LONG_PRESS_EN
  localparam int            HW    = cnt_width(LONG_TICKS > REP_TICKS ? LONG_TICKS : REP_TICKS);
  localparam logic [HW-1:0] L_END = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] R_END = HW'(REP_TICKS > 0 ? REP_TICKS - 1 : 0);
  localparam logic          REP   = (REP_TICKS > 0);

  logic [HW-1:0] hold;
  logic          rep, due;

  assign due = rep ? (REP && hold == R_END) : (hold == L_END);

  // Hold counter: first strobe after LONG_TICKS held cycles, then every REP_TICKS;
  // a release on the same edge clears everything so it always beats a due strobe.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold <= '0;
      rep  <= 1'b0;
      lng  <= 1'b0;
    end else if (!state || (fire && !p)) begin
      hold <= '0;
      rep  <= 1'b0;
      lng  <= 1'b0;
    end else begin
      lng  <= due;
      hold <= due ? '0 : (rep && !REP) ? hold : hold + 1'b1;
      rep  <= rep | due;
    end
`else
  assign lng = 1'b0;
`endif

  assign evt = '{state: state, press: press, rls: rls, lng: lng};

endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: NUM_BTN independent push-button conditioners packed onto vector ports.
// Optional long-press / auto-repeat strobes are built only when LONG_PRESS_EN is defined.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_BTN     = 4,
  parameter int CLK_KHZ     = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int ACTIVE_LOW  = 1,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int TICKS      = ms_to_ticks(CLK_KHZ, DEBOUNCE_MS);
  localparam int LONG_TICKS = ms_to_ticks(CLK_KHZ, LONG_MS);
  localparam int REP_TICKS  = ms_to_ticks(CLK_KHZ, REPEAT_MS);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_evt_t evt;
    debounce_ch #(
      .TICKS(TICKS),
      .ACTIVE_LOW(ACTIVE_LOW)
`ifdef LONG_PRESS_EN
      ,
      .LONG_TICKS(LONG_TICKS),
      .REP_TICKS(REP_TICKS)
`endif
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .pad(btn_in[i]),
      .evt(evt)
    );
    assign btn_state[i]   = evt.state;
    assign btn_press[i]   = evt.press;
    assign btn_release[i] = evt.rls;
    assign btn_long[i]    = evt.lng;
  end

`ifndef LONG_PRESS_EN
  logic unused_cfg;
  assign unused_cfg = ^{LONG_TICKS[0], REP_TICKS[0]};
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed checks of multi_debouncer (TICKS=8, LONG 40, REPEAT 16, active-low pads).
module tb_multi_debouncer;

`ifdef LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_in, btn_state, btn_press, btn_release, btn_long;
  int         vectors = 0, errs = 0;
  int         np[4] = '{default: 0};
  int         nr[4] = '{default: 0};
  int         nl[4] = '{default: 0};
  int         b0, b1;

  multi_debouncer #(
    .NUM_BTN(4), .CLK_KHZ(1), .DEBOUNCE_MS(8), .ACTIVE_LOW(1), .LONG_MS(40), .REPEAT_MS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_state(btn_state),
    .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  // Count strobe cycles per channel, sampled mid-cycle.
  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      np[i] += int'(btn_press[i]);
      nr[i] += int'(btn_release[i]);
      nl[i] += int'(btn_long[i]);
    end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int strobes();
    int s = 0;
    for (int i = 0; i < 4; i++) s += np[i] + nr[i] + nl[i];
    return s;
  endfunction

  initial begin
    rst_n  = 1'b0;
    btn_in = 4'hF;
    repeat (3) tick;
    chk("rst_state", btn_state, 4'h0);
    chk("rst_press", btn_press, 4'h0);
    chk("rst_release", btn_release, 4'h0);
    chk("rst_long", btn_long, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (50) tick;
    chk("idle_state", btn_state, 4'h0);
    chkn("idle_strobes", strobes(), 0);

    @(negedge clk) btn_in = 4'hE;
    repeat (9) tick;
    chk("t2_state_e9", btn_state, 4'h0);
    chk("t2_press_e9", btn_press, 4'h0);
    tick;
    chk("t2_state_e10", btn_state, 4'h1);
    chk("t2_press_e10", btn_press, 4'h1);
    tick;
    chk("t2_press_e11", btn_press, 4'h0);
    chk("t2_state_e11", btn_state, 4'h1);

    b0 = np[1];
    @(negedge clk) btn_in = 4'hC;
    repeat (5) @(negedge clk);
    btn_in = 4'hE;
    repeat (3) @(negedge clk);
    btn_in = 4'hC;
    repeat (9) tick;
    chk("t3_state_e9", btn_state, 4'h1);
    tick;
    chk("t3_state_e10", btn_state, 4'h3);
    chk("t3_press_e10", btn_press, 4'h2);
    repeat (5) tick;
    chkn("t3_press_count", np[1] - b0, 1);

    b0 = np[2];
    b1 = nr[2];
    @(negedge clk) btn_in = 4'h8;
    repeat (30) @(negedge clk);
    btn_in = 4'hC;
    repeat (9) tick;
    chk("t4_state_e9", btn_state, 4'h7);
    tick;
    chk("t4_release_e10", btn_release, 4'h4);
    chk("t4_state_e10", btn_state, 4'h3);
    tick;
    chk("t4_release_e11", btn_release, 4'h0);
    repeat (3) tick;
    chkn("t4_release_count", nr[2] - b1, 1);
    chkn("t4_press_count", np[2] - b0, 1);

    @(negedge clk) btn_in = 4'hD;
    repeat (12) tick;
    chk("t5_ch0_released", btn_state, 4'h2);
    @(negedge clk) btn_in = 4'h4;
    repeat (9) tick;
    chk("t5_press_e9", btn_press, 4'h0);
    tick;
    chk("t5_press_e10", btn_press, 4'h9);
    chk("t5_state_e10", btn_state, 4'hB);

    for (int k = 1; k <= 120; k++) begin
      tick;
      chk("t6_long", btn_long & 4'h9,
          {LP && (k == 40 || k == 56 || k == 72 || k == 88 || k == 104 || k == 120), 2'b00,
           LP && (k == 40 || k == 56 || k == 72 || k == 88)});
      if (k == 99) begin
        chk("t6_release", btn_release, 4'h1);
        chk("t6_state", btn_state & 4'h9, 4'h8);
      end
      if (k == 89) btn_in = 4'h5;
    end

    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", btn_state, 4'h0);
    chk("t6_rst_press", btn_press, 4'h0);
    chk("t6_rst_release", btn_release, 4'h0);
    chk("t6_rst_long", btn_long, 4'h0);
    btn_in = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b0 = strobes();
    repeat (20) tick;
    chk("post_rst_state", btn_state, 4'h0);
    chkn("post_rst_strobes", strobes() - b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
